// File: rtl/product_bcd_conv_pkg.sv
// Shared constants and FSM state type for the product-to-BCD converter.
package product_bcd_conv_pkg;
  localparam int unsigned BITS_DEFAULT = 4;
  localparam int unsigned DIGITS       = 3;
  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned BCD_W        = DIGITS * DIGIT_W;
  // Counts 0 .. 2*bits-1 for the widest legal operand (bits=4).
  localparam int unsigned CNT_W        = $clog2(2 * BITS_DEFAULT);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;
endpackage

// File: rtl/product_bcd_conv_add3.sv
// Double-dabble digit adjust: add 3 to any BCD digit of 5 or more.
module bcd_add3
  import product_bcd_conv_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  output logic [DIGIT_W-1:0] y
);

  always_comb begin
    y = a;
    if (a >= DIGIT_W'(5)) y = a + DIGIT_W'(3);
  end

endmodule

// File: rtl/product_bcd_conv.sv
// Sequential double-dabble converter: binary product in, three packed BCD
// digits out, one product bit consumed per clock, MSB first.
module product_bcd_conv
  import product_bcd_conv_pkg::*;
#(
  parameter int unsigned bits = BITS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2*bits-1:0]  product_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               valid_o,
  output logic [BCD_W-1:0]   bcd_o
);

  state_t            state;
  logic [2*bits-1:0] shreg;
  logic [BCD_W-1:0]  scratch;
  logic [CNT_W-1:0]  cnt;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  nscratch;
  logic [2*bits-1:0] nshreg;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .a (scratch[DIGIT_W*g +: DIGIT_W]),
      .y (adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  // Adjusted digits and shift register move left together as one long word.
  always_comb begin
    nscratch = {adj[BCD_W-2:0], shreg[2*bits-1]};
    nshreg   = {shreg[2*bits-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      valid_o <= 1'b0;
      bcd_o   <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            shreg   <= product_i;
            scratch <= '0;
            cnt     <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= nscratch;
          shreg   <= nshreg;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(2*bits-1)) begin
            bcd_o   <= nscratch;
            done_o  <= 1'b1;
            valid_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed bench for product_bcd_conv with a queue of expected BCD results.
module tb_product_bcd_conv;

  localparam int unsigned BITS = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [2*BITS-1:0] product_i = '0;
  logic              busy_o;
  logic              done_o;
  logic              valid_o;
  logic [11:0]       bcd_o;

  product_bcd_conv #(.bits(BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .product_i (product_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .valid_o   (valid_o),
    .bcd_o     (bcd_o)
  );

  always #5 clk = ~clk;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;
  int unsigned edges     = 0;
  logic [11:0] sb[$];
  logic [11:0] last_bcd;

  function automatic logic [11:0] to_bcd(input int unsigned v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Drive one start cycle, then scramble product_i to prove it was latched.
  task automatic launch(input int unsigned p);
    start_i   = 1'b1;
    product_i = (2*BITS)'(p);
    sb.push_back(to_bcd(p));
    tick();
    edges     = 0;
    start_i   = 1'b0;
    product_i = (2*BITS)'($urandom);
  endtask

  // done_o is set by the 2*bits-th edge after the start edge, so the edge that
  // samples it high is the (2*bits+1)-th.
  task automatic wait_done(input string tag);
    logic [11:0] exp;
    while (done_o !== 1'b1 && edges < 20) tick();
    check({tag, "_latency"}, edges, 2*BITS);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_bcd"}, bcd_o, exp);
    end
    check({tag, "_valid"}, valid_o, 1'b1);
    check({tag, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    int unsigned dones;

    // Reset state
    tick(); tick();
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_bcd", bcd_o, 12'h000);
    rst = 1'b0;
    tick();

    // Maximum product 15x15
    launch(225);
    check("max_busy_start", busy_o, 1'b1);
    check("max_valid_start", valid_o, 1'b0);
    wait_done("max");
    tick();
    check("max_done_single", done_o, 1'b0);
    check("max_bcd_hold_idle", bcd_o, 12'h225);

    // Back-to-back: each start raised in the done cycle
    launch(0);
    check("b2b_hold_prev", bcd_o, 12'h225);
    wait_done("b2b_0");
    last_bcd = bcd_o;
    launch(99);
    check("b2b_busy_again", busy_o, 1'b1);
    check("b2b_hold_0", bcd_o, last_bcd);
    wait_done("b2b_99");
    launch(100);
    wait_done("b2b_100");

    // start_i during CONV is ignored
    tick();
    launch(42);
    repeat (3) tick();
    start_i   = 1'b1;
    product_i = 8'd7;
    tick();
    start_i   = 1'b0;
    wait_done("ignore");
    dones = 0;
    repeat (12) begin
      tick();
      if (done_o === 1'b1) dones++;
    end
    check("ignore_extra_done", dones, 0);
    check("ignore_bcd_final", bcd_o, 12'h042);

    // Reset aborts a running conversion
    launch(200);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("abort_busy", busy_o, 1'b0);
    check("abort_done", done_o, 1'b0);
    check("abort_valid", valid_o, 1'b0);
    check("abort_bcd", bcd_o, 12'h000);
    dones = 0;
    repeat (12) begin
      tick();
      if (done_o === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    launch(56);
    wait_done("after_abort");

    // Every 4x4 product
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(a * b);
        wait_done($sformatf("mul_%0d_%0d", a, b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/product_bcd_conv.md
PRODUCT_BCD_CONV -- requirements
Module: product_bcd_conv

Interface
REQ-001 Parameter: bits, default 4, operand width of the upstream multiplier; product width is 2*bits; legal range 2..4.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  request to convert product_i; sampled only in IDLE.
REQ-005 product_i  input  2*bits  binary product from the 4-bit multiplier (Product_o).
REQ-006 busy_o  output  1  high while a conversion is in progress.
REQ-007 done_o  output  1  one-cycle pulse marking a new result on bcd_o.
REQ-008 valid_o  output  1  high once bcd_o holds a completed result; low after reset and during conversion.
REQ-009 bcd_o  output  12  packed BCD result: [11:8] hundreds, [7:4] tens, [3:0] ones.

Function
REQ-010 The block SHALL convert the product with sequential double-dabble: one bit per clock, MSB first, 2*bits iterations.
REQ-011 The FSM SHALL have exactly two states: IDLE and CONV.
REQ-012 IDLE with start_i=1 SHALL, at that edge, latch product_i into a shift register, clear the 12-bit scratch digits, clear the iteration counter, clear valid_o, set busy_o and enter CONV.
REQ-013 IDLE with start_i=0 SHALL hold all outputs except done_o, which SHALL be 0.
REQ-014 In CONV, each edge SHALL add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one, and increment the counter.
REQ-015 On the edge completing iteration 2*bits, the block SHALL load bcd_o with the final scratch digits, set done_o=1 and valid_o=1, clear busy_o and return to IDLE.
REQ-016 Latency: done_o SHALL be high in the cycle 2*bits+1 rising edges after the edge that sampled start_i (9 edges for bits=4).
REQ-017 done_o SHALL be high for exactly one cycle per conversion.
REQ-018 start_i in CONV SHALL be ignored and SHALL NOT alter the running conversion.
REQ-019 start_i high in the cycle where done_o=1 (state IDLE) SHALL be accepted; back-to-back throughput is one result per 2*bits+1 cycles.
REQ-020 bcd_o SHALL hold its last result throughout a following conversion until overwritten per REQ-015.
REQ-021 Every digit of bcd_o SHALL be in 0..9; maximum result for bits=4 is 225 -> 12'h225.
REQ-022 product_i changes after the start edge SHALL NOT affect the result.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE and set busy_o=0, done_o=0, valid_o=0, bcd_o=12'h000, counter=0, scratch=0.
REQ-024 rst SHALL override start_i and any in-progress conversion; no done_o pulse SHALL follow an aborted conversion.
REQ-025 The first start_i after rst deasserts SHALL be accepted normally.

Structure
REQ-026 A shared package SHALL hold: bits default, DIGITS=3, BCD width 12, the FSM state encoding (IDLE, CONV) and the counter width.
REQ-027 One sub-module, bcd_add3, SHALL implement the 4-bit digit adjust (in>=5 ? in+3 : in); the top instantiates three.
REQ-028 All outputs SHALL be driven directly from registers.

Verification
REQ-029 Reset, then start_i=1 for one cycle with product_i=8'd225 (15x15) -> done_o pulse 9 edges later, bcd_o=12'h225, valid_o=1, busy_o=0.
REQ-030 product_i=0, then 99, then 100, run back-to-back with start_i raised in each done_o cycle -> bcd_o 12'h000, 12'h099, 12'h100; one done_o per result, 9-cycle spacing.
REQ-031 start_i=1 with product_i=42; pulse start_i with product_i=7 on edge 4 of CONV -> bcd_o=12'h042, single done_o.
REQ-032 Start conversion of 200, assert rst on edge 5 -> all outputs 0 next cycle, no done_o; then convert 56 -> bcd_o=12'h056.
REQ-033 Exhaustive: all A,B in 0..15 through the multiplier into this block -> decimal value of bcd_o equals A*B for all 256 pairs.
